// File: rtl/preproc_pix_streamer.sv
// Raster frame reader: scans pixel memory out as a valid/pixel stream with SOF/EOL tags.
// Build option: PIXSTREAM_TESTPAT_EN adds a (x+y) diagonal ramp selected by tpat_sel.
module preproc_pix_streamer #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int ADDR_W = 19,
  parameter int HBLANK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              tpat_sel,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              o_vld,
  output logic [7:0]        o_pix,
  output logic              o_sof,
  output logic              o_eol
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int HW = (HBLANK > 1) ? $clog2(HBLANK) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LINE,
    S_HBL,
    S_DRAIN
  } state_t;

  state_t            r_state;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [ADDR_W-1:0] r_addr;
  logic [HW-1:0]     r_hcnt;
  logic              r_dcnt;
  logic              r_act;
  logic              r_rd_en;
  logic              r_busy;
  logic              r_done;

  logic              r_s1_vld;
  logic              r_s1_sof;
  logic              r_s1_eol;
  logic              r_vld;
  logic [7:0]        r_pix;
  logic              r_sof;
  logic              r_eol;

  logic              w_xlast;
  logic              w_ylast;
  logic              w_rd_idle;
  logic              w_rd_run;
  logic [7:0]        w_pix;

  assign w_xlast = (r_x == XW'(IMG_W - 1));
  assign w_ylast = (r_y == YW'(IMG_H - 1));

`ifdef PIXSTREAM_TESTPAT_EN
  logic       r_tpat;
  logic       r_s1_tpat;
  logic [7:0] r_s1_ramp;

  assign w_rd_idle = ~tpat_sel;
  assign w_rd_run  = ~r_tpat;
  assign w_pix     = r_s1_tpat ? r_s1_ramp : mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tpat    <= 1'b0;
      r_s1_tpat <= 1'b0;
      r_s1_ramp <= 8'h00;
    end else begin
      if (r_state == S_IDLE && start)
        r_tpat <= tpat_sel;
      r_s1_tpat <= r_tpat;
      r_s1_ramp <= 8'(r_x) + 8'(r_y);
    end
  end
`else
  logic w_unused;

  assign w_unused  = tpat_sel;
  assign w_rd_idle = 1'b1;
  assign w_rd_run  = 1'b1;
  assign w_pix     = mem_rdata;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_addr  <= '0;
      r_hcnt  <= '0;
      r_dcnt  <= 1'b0;
      r_act   <= 1'b0;
      r_rd_en <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LINE;
            r_x     <= '0;
            r_y     <= '0;
            r_addr  <= '0;
            r_act   <= 1'b1;
            r_rd_en <= w_rd_idle;
            r_busy  <= 1'b1;
          end
        end
        S_LINE: begin
          r_addr <= r_addr + ADDR_W'(1);
          if (w_xlast) begin
            r_x <= '0;
            r_y <= r_y + YW'(1);
            if (w_ylast) begin
              r_state <= S_DRAIN;
              r_dcnt  <= 1'b0;
              r_act   <= 1'b0;
              r_rd_en <= 1'b0;
            end else if (HBLANK > 0) begin
              r_state <= S_HBL;
              r_hcnt  <= '0;
              r_act   <= 1'b0;
              r_rd_en <= 1'b0;
            end
          end else begin
            r_x <= r_x + XW'(1);
          end
        end
        S_HBL: begin
          if (r_hcnt == HW'(HBLANK - 1)) begin
            r_state <= S_LINE;
            r_act   <= 1'b1;
            r_rd_en <= w_rd_run;
          end else begin
            r_hcnt <= r_hcnt + HW'(1);
          end
        end
        S_DRAIN: begin
          // two cycles let the last read reach the output register
          if (r_dcnt) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_dcnt <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
      r_s1_sof <= 1'b0;
      r_s1_eol <= 1'b0;
      r_vld    <= 1'b0;
      r_pix    <= 8'h00;
      r_sof    <= 1'b0;
      r_eol    <= 1'b0;
    end else begin
      r_s1_vld <= r_act;
      r_s1_sof <= r_act & (r_x == '0) & (r_y == '0);
      r_s1_eol <= r_act & w_xlast;
      r_vld    <= r_s1_vld;
      r_pix    <= r_s1_vld ? w_pix : 8'h00;
      r_sof    <= r_s1_sof;
      r_eol    <= r_s1_eol;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign mem_rd_en = r_rd_en;
  assign mem_addr  = r_addr;
  assign o_vld     = r_vld;
  assign o_pix     = r_pix;
  assign o_sof     = r_sof;
  assign o_eol     = r_eol;

endmodule

// File: tb/tb_preproc_pix_streamer.sv
// Directed bench for preproc_pix_streamer: 4x3 frame with blanking, 4x2 frame without.
// Memory model returns the address as data one cycle after a strobe, 0xFF otherwise.
module tb_preproc_pix_streamer;

  localparam int W      = 4;
  localparam int H      = 3;
  localparam int HB     = 2;
  localparam int PER    = W + HB;
  localparam int T_LAST = (H - 1) * PER + W - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_start, a_tpat, a_busy, a_done, a_rd;
  logic [3:0] a_addr;
  logic [7:0] a_rdata, a_pix;
  logic       a_vld, a_sof, a_eol;
  logic       b_start, b_tpat, b_busy, b_done, b_rd;
  logic [3:0] b_addr;
  logic [7:0] b_rdata, b_pix;
  logic       b_vld, b_sof, b_eol;

  int n_tests = 0;
  int n_fail  = 0;

  preproc_pix_streamer #(
    .IMG_W(W), .IMG_H(H), .ADDR_W(4), .HBLANK(HB)
  ) dut (
    .clk(clk), .rst(rst), .start(a_start), .tpat_sel(a_tpat),
    .busy(a_busy), .done(a_done), .mem_rd_en(a_rd),
    .mem_addr(a_addr), .mem_rdata(a_rdata),
    .o_vld(a_vld), .o_pix(a_pix), .o_sof(a_sof), .o_eol(a_eol)
  );

  preproc_pix_streamer #(
    .IMG_W(4), .IMG_H(2), .ADDR_W(4), .HBLANK(0)
  ) dut_nb (
    .clk(clk), .rst(rst), .start(b_start), .tpat_sel(b_tpat),
    .busy(b_busy), .done(b_done), .mem_rd_en(b_rd),
    .mem_addr(b_addr), .mem_rdata(b_rdata),
    .o_vld(b_vld), .o_pix(b_pix), .o_sof(b_sof), .o_eol(b_eol)
  );

  always_ff @(posedge clk) begin
    a_rdata <= a_rd ? 8'(a_addr) : 8'hFF;
    b_rdata <= b_rd ? 8'(b_addr) : 8'hFF;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit rd_slot(int c);
    return c >= 0 && (c / PER) < H && (c % PER) < W;
  endfunction

  function automatic int slot_idx(int c);
    return (c / PER) * W + (c % PER);
  endfunction

  task automatic start_a(input bit tp);
    @(negedge clk);
    a_start = 1'b1;
    a_tpat  = tp;
    @(negedge clk);
    check("start_busy", a_busy, 1);
    check("start_addr0", a_addr, 0);
  endtask

  // c = 0 is the first read cycle, already at its negedge on entry
  task automatic scan_a(input bit tp, input bit hold, input bit b2b);
    int rd_err, addr_err, vld_err, mk_err, busy_err;
    int ff_n, npix, done_c, k, e;
    bit mem_mode;
    rd_err = 0; addr_err = 0; vld_err = 0; mk_err = 0; busy_err = 0;
    ff_n = 0; npix = 0; done_c = -1;
    mem_mode = 1'b1;
`ifdef PIXSTREAM_TESTPAT_EN
    mem_mode = !tp;
`endif
    if (!hold) a_start = 1'b0;
    for (int c = 0; c <= T_LAST + 3; c++) begin
      if (c > 0) @(negedge clk);
      if (hold && c == T_LAST + 2) a_start = 1'b0;
      if (a_rd !== (rd_slot(c) && mem_mode)) rd_err++;
      if (rd_slot(c) && a_addr !== 4'(slot_idx(c))) addr_err++;
      if (a_vld !== rd_slot(c - 2)) vld_err++;
      if (a_vld === 1'b1) begin
        k = slot_idx(c - 2);
        e = mem_mode ? k : (k / W) + (k % W);
        check("pix", a_pix, e);
        npix++;
        if (a_pix == 8'hFF) ff_n++;
        if (a_sof !== (k == 0) || a_eol !== (k % W == W - 1)) mk_err++;
      end else if (a_sof !== 1'b0 || a_eol !== 1'b0) begin
        mk_err++;
      end
      if (a_busy !== (c <= T_LAST + 2)) busy_err++;
      if (a_done === 1'b1 && done_c < 0) done_c = c;
      if (b2b && c == T_LAST + 3) a_start = 1'b1;
    end
    check("rd_pattern", rd_err, 0);
    check("addr_seq", addr_err, 0);
    check("vld_pattern", vld_err, 0);
    check("markers", mk_err, 0);
    check("busy_window", busy_err, 0);
    check("pix_count", npix, W * H);
    check("no_ff", ff_n, 0);
    check("done_cycle", done_c, T_LAST + 3);
  endtask

  task automatic idle_a(input string tag, input int n);
    int err;
    err = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (a_busy !== 1'b0 || a_done !== 1'b0 || a_rd !== 1'b0 ||
          a_vld !== 1'b0) err++;
    end
    check(tag, err, 0);
  endtask

  initial begin
    int c5;
    int b_vld_n, b_done_c, b_busy_d, b_busy_pre, b_err;
    rst = 1'b1;
    a_start = 1'b0; a_tpat = 1'b0;
    b_start = 1'b0; b_tpat = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {a_busy, a_done, a_rd, a_vld, a_sof, a_eol}, 0);
    check("rst_addr", a_addr, 0);
    check("rst_pix", a_pix, 0);
    rst = 1'b0;
    idle_a("idle_no_start", 3);

    // plain frame
    start_a(1'b0);
    scan_a(1'b0, 1'b0, 1'b0);
    idle_a("after_frame", 4);

    // start held through the frame gives exactly one frame
    start_a(1'b0);
    scan_a(1'b0, 1'b1, 1'b0);
    idle_a("hold_one_frame", 8);

    // start in the done cycle launches the next frame
    start_a(1'b0);
    scan_a(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("b2b_busy", a_busy, 1);
    check("b2b_rd", a_rd, 1);
    check("b2b_addr0", a_addr, 0);
    scan_a(1'b0, 1'b0, 1'b0);
    idle_a("after_b2b", 3);

    // reset right after pixel 5 is out
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    c5 = -1;
    for (int c = 0; c < 30 && c5 < 0; c++) begin
      if (a_vld === 1'b1 && a_pix == 8'd5) c5 = c;
      else @(negedge clk);
    end
    check("pix5_seen", c5, 9);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ctrl", {a_busy, a_done, a_rd, a_vld, a_sof, a_eol}, 0);
    check("abort_addr", a_addr, 0);
    check("abort_pix", a_pix, 0);
    idle_a("abort_no_done", 25);
    start_a(1'b0);
    scan_a(1'b0, 1'b0, 1'b0);

    // tpat_sel: ramp with the option built in, memory frame otherwise
    start_a(1'b1);
    scan_a(1'b1, 1'b0, 1'b0);
    a_tpat = 1'b0;
    idle_a("after_tpat", 3);

    // no blanking: 8 back-to-back pixels, done right after the last
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    b_vld_n = 0; b_done_c = -1; b_busy_d = -1; b_busy_pre = -1; b_err = 0;
    for (int c = 0; c < 14; c++) begin
      if (c > 0) @(negedge clk);
      if (b_vld !== (c >= 2 && c <= 9)) b_err++;
      if (b_vld === 1'b1) begin
        b_vld_n++;
        check("nb_pix", b_pix, c - 2);
      end
      if (c == 9) b_busy_pre = int'(b_busy);
      if (b_done === 1'b1 && b_done_c < 0) begin
        b_done_c = c;
        b_busy_d = int'(b_busy);
      end
    end
    check("nb_vld_pattern", b_err, 0);
    check("nb_vld_count", b_vld_n, 8);
    check("nb_done_cycle", b_done_c, 10);
    check("nb_busy_at_done", b_busy_d, 0);
    check("nb_busy_last_pix", b_busy_pre, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
